// File: rtl/store_data_formatter.sv
// Store path formatter: narrows a register value to a word-aligned memory
// write with byte enables, with a valid/ready core handshake, a req/ack
// memory handshake and one-cycle done/err status pulses.
module store_data_formatter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [1:0]  st_size,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] EC_MISALIGN = 2'b01;
  localparam logic [1:0] EC_ILLEGAL  = 2'b10;
  localparam logic [1:0] EC_TIMEOUT  = 2'b11;

  // Last REQ cycle index before a timeout; counter starts at 0 on entry.
  localparam logic [7:0] LP_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic [7:0]  r_count;
  logic        r_mem_req;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_be;
  logic        r_done;
  logic        r_err;
  logic [1:0]  r_err_code;

  logic [31:0] w_wdata;
  logic [3:0]  w_be;
  logic        w_misaligned;

  // Lane replication and byte-enable generation for the incoming request
  always_comb begin
    w_wdata = st_data;
    w_be    = 4'b1111;
    case (st_size)
      SZ_BYTE: begin
        w_wdata = {4{st_data[7:0]}};
        w_be    = 4'b0001 << st_addr[1:0];
      end
      SZ_HALF: begin
        w_wdata = {2{st_data[15:0]}};
        w_be    = st_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        w_wdata = st_data;
        w_be    = 4'b1111;
      end
    endcase
  end

  assign w_misaligned = ((st_size == SZ_HALF) && st_addr[0]) ||
                        ((st_size == SZ_WORD) && (st_addr[1:0] != 2'b00));

  // Store sequencing FSM; all handshake and status outputs are registered
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_count     <= 8'd0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_mem_be    <= 4'd0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= 2'b00;
    end else begin
      // Status pulses last exactly one cycle unless re-armed below.
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= 2'b00;
      case (r_state)
        S_IDLE: begin
          if (st_valid) begin
            if (st_size == 2'b11) begin
              r_state    <= S_ERR;
              r_err      <= 1'b1;
              r_err_code <= EC_ILLEGAL;
            end else if (w_misaligned) begin
              r_state    <= S_ERR;
              r_err      <= 1'b1;
              r_err_code <= EC_MISALIGN;
            end else begin
              r_state     <= S_REQ;
              r_count     <= 8'd0;
              r_mem_req   <= 1'b1;
              r_mem_addr  <= {st_addr[31:2], 2'b00};
              r_mem_wdata <= w_wdata;
              r_mem_be    <= w_be;
            end
          end
        end
        S_REQ: begin
          // An ack on the last allowed cycle still completes the store.
          if (mem_ack) begin
            r_state     <= S_DONE;
            r_done      <= 1'b1;
            r_mem_req   <= 1'b0;
            r_mem_wdata <= 32'd0;
            r_mem_be    <= 4'd0;
          end else if (r_count == LP_LAST) begin
            r_state     <= S_ERR;
            r_err       <= 1'b1;
            r_err_code  <= EC_TIMEOUT;
            r_mem_req   <= 1'b0;
            r_mem_wdata <= 32'd0;
            r_mem_be    <= 4'd0;
          end else begin
            r_count <= r_count + 8'd1;
          end
        end
        S_DONE: r_state <= S_IDLE;
        S_ERR:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign st_ready  = (r_state == S_IDLE);
  assign mem_req   = r_mem_req;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_be    = r_mem_be;
  assign done      = r_done;
  assign err       = r_err;
  assign err_code  = r_err_code;

endmodule

// File: tb/tb_store_data_formatter.sv
// Testbench for store_data_formatter: directed stores, a per-cycle trace
// model checked on every falling edge, and literal pins on key results.
module tb_store_data_formatter;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic        done;
  logic        err;
  logic [1:0]  err_code;

  always #5 clk = ~clk;

  store_data_formatter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack),
    .done(done), .err(err), .err_code(err_code)
  );

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        dn;
    logic        er;
    logic [1:0]  code;
    logic        rdy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  // Observations gathered by the compare process, read as deltas by tests.
  int          req_cycles  = 0;
  int          done_pulses = 0;
  int          err_pulses  = 0;
  logic [31:0] seen_addr   = '0;
  logic [31:0] seen_wdata  = '0;
  logic [3:0]  seen_be     = '0;
  logic [1:0]  seen_code   = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: what a legal store of width 1/2/4 bytes puts on the bus.
  function automatic void model(input logic [31:0] a, input logic [31:0] d,
                                input logic [1:0] sz, output logic [31:0] w,
                                output logic [3:0] be, output int ecode);
    int width;
    int off;
    width = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    off   = int'(a[1:0]);
    w     = '0;
    be    = '0;
    if (sz == 2'd3)            ecode = 2;
    else if (off % width != 0) ecode = 1;
    else                       ecode = 0;
    for (int lane = 0; lane < 4; lane++) begin
      w[lane*8 +: 8] = d[(lane % width)*8 +: 8];
      be[lane]       = (lane >= off) && (lane < off + width);
    end
  endfunction

  function automatic exp_t mk(input logic req, input logic [31:0] a, input logic [31:0] w,
                              input logic [3:0] be, input logic dn, input logic er,
                              input logic [1:0] code);
    exp_t e;
    e.req = req; e.addr = a; e.wdata = w; e.be = be;
    e.dn = dn; e.er = er; e.code = code; e.rdy = 1'b0;
    return e;
  endfunction

  // Compare DUT outputs with the expected trace every cycle; idle when empty.
  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      if (mem_req) begin
        req_cycles++;
        seen_addr  = mem_addr;
        seen_wdata = mem_wdata;
        seen_be    = mem_be;
      end
      if (done) done_pulses++;
      if (err) begin
        err_pulses++;
        seen_code = err_code;
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
      end else begin
        e = mk(1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 2'd0);
        e.rdy = 1'b1;
      end
      check("mem_req", {31'd0, mem_req}, {31'd0, e.req});
      check("mem_wdata", mem_wdata, e.wdata);
      check("mem_be", {28'd0, mem_be}, {28'd0, e.be});
      check("done", {31'd0, done}, {31'd0, e.dn});
      check("err", {31'd0, err}, {31'd0, e.er});
      check("err_code", {30'd0, err_code}, {30'd0, e.code});
      check("st_ready", {31'd0, st_ready}, {31'd0, e.rdy});
      if (e.req) check("mem_addr", mem_addr, e.addr);
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!st_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_wait", {31'd0, st_ready}, 32'd1);
  endtask

  // One store; ack_at = REQ cycle (1-based) on which ack is given, 0 = never.
  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                       input int ack_at, input bit keep_valid);
    logic [31:0] w;
    logic [3:0]  be;
    int          ec;
    int          n;
    bit          acked;
    wait_ready();
    st_addr = a; st_data = d; st_size = sz; st_valid = 1'b1; mem_ack = 1'b0;
    @(posedge clk); #1;
    if (!keep_valid) st_valid = 1'b0;
    model(a, d, sz, w, be, ec);
    if (ec != 0) begin
      exp_q.push_back(mk(1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b1, 2'(ec)));
      @(posedge clk); #1;
    end else begin
      acked = (ack_at >= 1 && ack_at <= TO);
      n     = acked ? ack_at : TO;
      for (int i = 1; i <= n; i++)
        exp_q.push_back(mk(1'b1, {a[31:2], 2'b00}, w, be, 1'b0, 1'b0, 2'd0));
      exp_q.push_back(mk(1'b0, 32'd0, 32'd0, 4'd0, acked, !acked, acked ? 2'd0 : 2'd3));
      for (int i = 1; i <= n; i++) begin
        mem_ack = (i == ack_at);
        @(posedge clk); #1;
      end
      mem_ack = 1'b1;  // ack outside REQ must be ignored
      @(posedge clk); #1;
      mem_ack = 1'b0;
    end
  endtask

  initial begin
    int r0, d0, e0;
    reset = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_size = '0; mem_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_be", {28'd0, mem_be}, 32'd0);
    check("rst_st_ready", {31'd0, st_ready}, 32'd1);
    chk_en = 1'b1;
    @(posedge clk); #1;

    // SB to byte lane 3, ack on the first REQ cycle
    r0 = req_cycles; d0 = done_pulses;
    store(32'h0000_1003, 32'hAABB_CCDD, 2'b00, 1, 1'b0);
    check("sb_addr", seen_addr, 32'h0000_1000);
    check("sb_wdata", seen_wdata, 32'hDDDD_DDDD);
    check("sb_be", {28'd0, seen_be}, 32'h8);
    check("sb_req_cycles", req_cycles - r0, 1);
    check("sb_done", done_pulses - d0, 1);

    // SH upper half, ack after three REQ cycles
    r0 = req_cycles; d0 = done_pulses;
    store(32'h0000_2002, 32'h1234_5678, 2'b01, 3, 1'b0);
    check("sh_wdata", seen_wdata, 32'h5678_5678);
    check("sh_be", {28'd0, seen_be}, 32'hC);
    check("sh_req_cycles", req_cycles - r0, 3);
    check("sh_done", done_pulses - d0, 1);

    // Misaligned word, then illegal size
    r0 = req_cycles; e0 = err_pulses;
    store(32'h0000_3001, 32'hCAFE_F00D, 2'b10, 1, 1'b0);
    check("mis_code", {30'd0, seen_code}, 32'd1);
    store(32'h0000_3000, 32'hCAFE_F00D, 2'b11, 1, 1'b0);
    check("ill_code", {30'd0, seen_code}, 32'd2);
    check("err_req_cycles", req_cycles - r0, 0);
    check("err_pulses", err_pulses - e0, 2);

    // Timeout, then ack on the final allowed cycle
    r0 = req_cycles; d0 = done_pulses; e0 = err_pulses;
    store(32'h0000_4000, 32'h0BAD_BEEF, 2'b10, 0, 1'b0);
    check("to_req_cycles", req_cycles - r0, 16);
    check("to_code", {30'd0, seen_code}, 32'd3);
    r0 = req_cycles;
    store(32'h0000_4000, 32'h0BAD_BEEF, 2'b10, 16, 1'b0);
    check("last_ack_req_cycles", req_cycles - r0, 16);
    check("last_ack_done", done_pulses - d0, 1);
    check("last_ack_err", err_pulses - e0, 1);

    // Reset during the second REQ cycle abandons the store silently
    d0 = done_pulses; e0 = err_pulses;
    wait_ready();
    st_addr = 32'h0000_4000; st_data = 32'h1111_2222; st_size = 2'b10; st_valid = 1'b1;
    @(posedge clk); #1;
    st_valid = 1'b0;
    exp_q.push_back(mk(1'b1, 32'h0000_4000, 32'h1111_2222, 4'hF, 1'b0, 1'b0, 2'd0));
    exp_q.push_back(mk(1'b1, 32'h0000_4000, 32'h1111_2222, 4'hF, 1'b0, 1'b0, 2'd0));
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst2_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst2_mem_addr", mem_addr, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst2_no_pulse", (done_pulses - d0) + (err_pulses - e0), 0);
    store(32'h0000_5001, 32'h0000_00EE, 2'b00, 2, 1'b0);
    check("post_rst_wdata", seen_wdata, 32'hEEEE_EEEE);
    check("post_rst_be", {28'd0, seen_be}, 32'h2);
    store(32'h0000_6000, 32'h0000_BEEF, 2'b01, 1, 1'b0);
    check("sh_low_be", {28'd0, seen_be}, 32'h3);

    // Back-to-back with st_valid held high throughout
    r0 = req_cycles; d0 = done_pulses;
    begin
      int a1, a2, a3;
      a1 = int'($urandom_range(1, 4));
      a2 = int'($urandom_range(1, 4));
      a3 = int'($urandom_range(1, 4));
      store(32'h0000_7000, 32'h0101_0101, 2'b10, a1, 1'b1);
      store(32'h0000_7006, 32'h0000_ABCD, 2'b01, a2, 1'b1);
      store(32'h0000_7009, 32'h0000_0042, 2'b00, a3, 1'b0);
      check("b2b_req_cycles", req_cycles - r0, a1 + a2 + a3);
      check("b2b_done", done_pulses - d0, 3);
      check("b2b_last_be", {28'd0, seen_be}, 32'h2);
    end

    repeat (3) @(posedge clk);
    #1;
    check("trace_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/store_data_formatter.md
Name: store_data_formatter

Overview:
Sequential store path between the datapath and data memory. It takes a 32-bit register value plus the store size (SB/SH/SW) and narrows it into a word-aligned memory write with byte enables. This is the inverse of immediate/load widening. It runs a valid/ready handshake toward the core and a req/ack handshake toward memory, and reports misalignment, illegal size and memory timeout as one-cycle error pulses.

Parameters:
TIMEOUT_CYCLES, 16, number of consecutive REQ cycles without mem_ack before a timeout error (legal range 2..255).

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
st_valid  input  1  core presents a store request
st_ready  output  1  block can accept a request (high only in IDLE)
st_addr  input  32  byte address of the store
st_data  input  32  register value; only the low byte/half is used for SB/SH
st_size  input  2  00=byte, 01=half, 10=word, 11=illegal
mem_req  output  1  memory write request, held until ack or timeout
mem_addr  output  32  word-aligned address {st_addr[31:2],2'b00}
mem_wdata  output  32  lane-replicated write data
mem_be  output  4  byte enables, bit i = byte lane i (little-endian)
mem_ack  input  1  memory accepted the write
done  output  1  one-cycle pulse: store completed
err  output  1  one-cycle pulse: store aborted
err_code  output  2  00 none, 01 misaligned, 10 illegal size, 11 timeout; nonzero only while err=1

Behaviour:
- Reset (synchronous): state=IDLE, timeout counter=0. mem_req, mem_addr, mem_wdata, mem_be, done, err and err_code are all 0. Reset mid-transaction abandons the store with no done/err pulse. st_ready=1 on the first cycle after reset deasserts.
- FSM states: IDLE, REQ, DONE, ERR. st_ready = (state==IDLE), combinational.
- IDLE: the request is accepted when st_valid && st_ready at edge T. Registered outputs are valid from cycle T+1.
  - st_size=11 -> ERR with code 10.
  - half with st_addr[0]=1, or word with st_addr[1:0]!=00 -> ERR with code 01.
  - Otherwise -> REQ. Latch mem_addr, mem_wdata and mem_be, set mem_req=1, clear the counter.
- Lane formatting:
  - byte: wdata={4{st_data[7:0]}}, be=4'b0001<<st_addr[1:0].
  - half: wdata={2{st_data[15:0]}}, be = st_addr[1] ? 4'b1100 : 4'b0011.
  - word: wdata=st_data, be=4'b1111.
- REQ: mem_req, mem_addr, mem_wdata and mem_be are held stable every cycle.
  - mem_ack=1 sampled -> DONE. mem_req drops the next cycle.
  - Otherwise the counter increments. If the counter reaches TIMEOUT_CYCLES-1 with no ack -> ERR with code 11.
  - An ack on the final timeout cycle wins, giving DONE rather than a timeout.
- DONE: done=1 for exactly one cycle, then IDLE.
- ERR: err=1 and err_code valid for exactly one cycle, then IDLE.
- On leaving REQ, mem_req, mem_be and mem_wdata return to 0. mem_addr may hold its value.
- mem_ack in IDLE/DONE/ERR is ignored. No memory access is issued for error cases (mem_req stays 0).
- Minimum turnaround: accept -> REQ -> DONE -> IDLE is 3 cycles when ack arrives on the first REQ cycle. st_valid is not consumed outside IDLE.
- done and err are never high together. At most one outstanding store.

Test Plan:
- Reset, then SB addr=0x1003 data=0xAABBCCDD, ack on first REQ cycle -> mem_addr=0x1000, wdata=0xDDDDDDDD, be=1000, done pulse 2 cycles after accept, st_ready back 3 cycles after accept.
- SH addr=0x2002 data=0x12345678, ack after 3 REQ cycles -> wdata=0x56785678, be=1100, mem_req high exactly 3 cycles with stable outputs, done pulse once.
- SW addr=0x3001 -> err=1, err_code=01 the cycle after accept, mem_req never asserted; then st_size=11 -> err_code=10.
- SW addr=0x4000, no ack, TIMEOUT_CYCLES=16 -> mem_req high 16 cycles, then err with err_code=11, mem_req=0. Repeat with ack on the 16th REQ cycle -> done, no err.
- Assert reset while in REQ (cycle 2) -> next cycle mem_req=0, be=0, no done/err pulse. A new SB after reset completes normally.
- Back-to-back: st_valid held high with three stores and random ack delays -> each accepted only when st_ready=1, three done pulses in order, no lost or duplicated mem_req.
